// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch stage: CPU widths, the nop encoding,
// fetch exception tag bit positions and the sequential PC increment.
// No ports; imported by fetch_queue and fetch_queue_fifo.
package fetch_queue_pkg;

   // Core-wide widths; the fetch_queue width parameters are expected to match these
   localparam int CPU_ADDR_WIDTH  = 32;
   localparam int CPU_INSTR_WIDTH = 32;

   // All-zero word decodes as a nop, used for empty heads and error entries
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Fetch exception tag layout: {bus, align}
   localparam int EXC_WIDTH       = 2;
   localparam int FETCH_EXC_ALIGN = 0;
   localparam int FETCH_EXC_BUS   = 1;

   // Distance between sequential fetch addresses
   localparam int PC_INC = 4;

   // Packs the IFU error flags into the exception tag
   function automatic logic [EXC_WIDTH-1:0] make_exc_tag(input logic err_bus,
                                                         input logic err_align);
      logic [EXC_WIDTH-1:0] tag;
      tag                  = '0;
      tag[FETCH_EXC_BUS]   = err_bus;
      tag[FETCH_EXC_ALIGN] = err_align;
      return tag;
   endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO holding fetched entries {except, pc, instr}.
// Ports:
//   clk, nrst       clock, asynchronous active-low reset
//   i_flush         drop all entries (wins over push/pop)
//   i_push, i_data  write one entry at the tail
//   i_pop           remove the head entry
//   o_head          current head entry (meaningful only when o_count != 0)
//   o_count         number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fetch_queue_fifo
   import fetch_queue_pkg::*;
#(
   parameter int WIDTH = 66,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Next-state for storage, pointers and occupancy; flush only resets the
   // bookkeeping since stale storage is never visible with count at zero
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (i_push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (i_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (i_push && !i_pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (!i_push && i_pop) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign o_head  = mem_q[rd_ptr_q];
   assign o_count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a prefetch queue. Owns the sequential fetch
// pointer, issues single-outstanding reads to the IFU, buffers up to DEPTH
// fetched words with PC and error tag, and hands them to decode.
// Ports:
//   clk, nrst                      clock, asynchronous active-low reset
//   i_redir_valid, i_redir_pc      redirect pulse and target from the CU
//   o_valid, i_ready               decode handshake on the queue head
//   o_instr, o_pc, o_except        head entry (nop/zero when o_valid=0)
//   o_fetch_stall                  decode starved (o_valid=0)
//   o_addr, o_rd_cmd               IFU read address and command pulse
//   i_instr_dat, i_busy            IFU read data and busy flag
//   i_err_align, i_err_bus         IFU error flags, valid with a response
// ADDR_WIDTH/INSTR_WIDTH are expected to equal CPU_ADDR_WIDTH/CPU_INSTR_WIDTH;
// DEPTH must be a power of two in 2..16.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    DEPTH       = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   i_redir_valid,
   input  logic [ADDR_WIDTH-1:0]  i_redir_pc,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [ADDR_WIDTH-1:0]  o_pc,
   output logic [EXC_WIDTH-1:0]   o_except,
   output logic                   o_fetch_stall,
   output logic [ADDR_WIDTH-1:0]  o_addr,
   output logic                   o_rd_cmd,
   input  logic [INSTR_WIDTH-1:0] i_instr_dat,
   input  logic                   i_busy,
   input  logic                   i_err_align,
   input  logic                   i_err_bus
);

   localparam int ENTRY_W = EXC_WIDTH + ADDR_WIDTH + INSTR_WIDTH;
   localparam int CNT_W   = $clog2(DEPTH+1);

   logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
   logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
   logic                  inflight_q, inflight_d;
   logic                  drop_q, drop_d;
   logic                  halt_q, halt_d;
   logic                  run_q, run_d;

   logic                  resp;
   logic                  resp_err;
   logic                  push;
   logic                  pop;
   logic                  issue;
   logic                  head_valid;
   logic [CNT_W:0]        occupancy;
   logic [CNT_W-1:0]      count;
   logic [ENTRY_W-1:0]    head;
   logic [ENTRY_W-1:0]    push_data;

   // Event decode. The read command is derived from registered state plus the
   // IFU's completion in this cycle, so a zero-wait IFU can take a new command
   // in the same cycle it returns data. i_ready never reaches the issue path:
   // occupancy uses the registered count, ignoring a pop in flight.
   // run_q holds off the very first command until one edge after reset release.
   always_comb begin
      resp       = inflight_q && !i_busy;
      resp_err   = i_err_bus || i_err_align;
      push       = resp && !drop_q && !i_redir_valid;
      head_valid = (count != '0);
      pop        = head_valid && i_ready && !i_redir_valid;
      occupancy  = {1'b0, count} + (CNT_W+1)'(inflight_q);
      issue      = run_q && !halt_q && !i_redir_valid
                   && (occupancy < (CNT_W+1)'(DEPTH))
                   && (!inflight_q || (resp && !drop_q && !resp_err));
      push_data  = {make_exc_tag(i_err_bus, i_err_align),
                    req_pc_q,
                    resp_err ? INSTR_WIDTH'(NOP_INSTR) : i_instr_dat};
   end

   // Next state for the fetch pointer and the transaction flags. A redirect
   // while a read is still pending marks its response for discard; the
   // pending flag stays set so no second read goes out until it completes.
   always_comb begin
      fpc_d      = fpc_q;
      req_pc_d   = req_pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      halt_d     = halt_q;
      run_d      = 1'b1;
      if (i_redir_valid) begin
         fpc_d = i_redir_pc;
      end else if (issue) begin
         fpc_d = fpc_q + ADDR_WIDTH'(PC_INC);
      end
      if (issue) begin
         req_pc_d   = fpc_q;
         inflight_d = 1'b1;
      end else if (resp) begin
         inflight_d = 1'b0;
      end
      if (resp) begin
         drop_d = 1'b0;
      end else if (i_redir_valid && inflight_q) begin
         drop_d = 1'b1;
      end
      if (i_redir_valid) begin
         halt_d = 1'b0;
      end else if (push && resp_err) begin
         halt_d = 1'b1;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         fpc_q      <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
         halt_q     <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         fpc_q      <= fpc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         halt_q     <= halt_d;
         run_q      <= run_d;
      end
   end

   fetch_queue_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .nrst    (nrst),
      .i_flush (i_redir_valid),
      .i_push  (push),
      .i_data  (push_data),
      .i_pop   (pop),
      .o_head  (head),
      .o_count (count)
   );

   // Head presentation; an empty queue shows a nop with zero PC and tag
   always_comb begin
      o_valid       = head_valid;
      o_fetch_stall = !head_valid;
      o_instr       = INSTR_WIDTH'(NOP_INSTR);
      o_pc          = '0;
      o_except      = '0;
      if (head_valid) begin
         o_instr  = head[INSTR_WIDTH-1:0];
         o_pc     = head[INSTR_WIDTH +: ADDR_WIDTH];
         o_except = head[ENTRY_W-1 -: EXC_WIDTH];
      end
      o_addr   = fpc_q;
      o_rd_cmd = issue;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a small IFU responder.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        i_redir_valid = 1'b0;
   logic [31:0] i_redir_pc = '0;
   logic        i_ready = 1'b0;
   logic        o_valid;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic [1:0]  o_except;
   logic        o_fetch_stall;
   logic [31:0] o_addr;
   logic        o_rd_cmd;
   logic [31:0] i_instr_dat;
   logic        i_busy;
   logic        i_err_align;
   logic        i_err_bus;

   int testsRun = 0;
   int testsFailed = 0;
   int cyc = 0;

   fetch_queue dut (
      .clk           (clk),
      .nrst          (nrst),
      .i_redir_valid (i_redir_valid),
      .i_redir_pc    (i_redir_pc),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_instr       (o_instr),
      .o_pc          (o_pc),
      .o_except      (o_except),
      .o_fetch_stall (o_fetch_stall),
      .o_addr        (o_addr),
      .o_rd_cmd      (o_rd_cmd),
      .i_instr_dat   (i_instr_dat),
      .i_busy        (i_busy),
      .i_err_align   (i_err_align),
      .i_err_bus     (i_err_bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents seen by the IFU model
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // IFU model: latches a command, stays busy ifuLat cycles, then responds
   int          ifuLat = 0;
   int          ifuWait = 0;
   logic [31:0] ifuAddr = '0;
   logic [31:0] busErrAddr = 32'hFFFF_FFFF;
   bit          busErrEn = 1'b0;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ifuWait <= 0;
      end else if (o_rd_cmd) begin
         ifuWait <= ifuLat;
         ifuAddr <= o_addr;
      end else if (ifuWait > 0) begin
         ifuWait <= ifuWait - 1;
      end
   end

   assign i_busy      = (ifuWait != 0);
   assign i_instr_dat = memWord(ifuAddr);
   assign i_err_align = (ifuAddr[1:0] != 2'b00);
   assign i_err_bus   = busErrEn && (ifuAddr == busErrAddr);

   // Logs of commands and accepted head entries
   logic [31:0] cmdAddr[$];
   logic [31:0] cmdCyc[$];
   logic [31:0] popPc[$];
   logic [31:0] popInstr[$];
   logic [31:0] popExc[$];
   logic [31:0] popCyc[$];

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (nrst) begin
         if (o_rd_cmd) begin
            cmdAddr.push_back(o_addr);
            cmdCyc.push_back(32'(cyc));
         end
         if (o_valid && i_ready && !i_redir_valid) begin
            popPc.push_back(o_pc);
            popInstr.push_back(o_instr);
            popExc.push_back({30'd0, o_except});
            popCyc.push_back(32'(cyc));
         end
         if (!o_valid) begin
            checkOutput("idle_nop", {32'd0, o_instr}, 64'd0);
         end
      end
   end

   function automatic logic [31:0] qAt(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic clearLogs();
      cmdAddr.delete(); cmdCyc.delete();
      popPc.delete(); popInstr.delete(); popExc.delete(); popCyc.delete();
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic redir, input logic [31:0] pc, input logic ready);
      i_redir_valid = redir;
      i_redir_pc    = pc;
      i_ready       = ready;
   endtask

   task automatic resetDut(output int rel);
      nrst = 1'b0;
      waitCycles(2);
      clearLogs();
      nrst = 1'b1;
      rel  = cyc;
   endtask

   task automatic pulseRedirect(input logic [31:0] pc, output int rcyc);
      applyStimulus(1'b1, pc, i_ready);
      rcyc = cyc;
      waitCycles(1);
      i_redir_valid = 1'b0;
   endtask

   initial begin
      int rel;
      int rcyc;
      int k;

      // Reset values and streaming with a zero-wait IFU
      applyStimulus(1'b0, 32'd0, 1'b1);
      ifuLat = 0;
      waitCycles(3);
      checkOutput("rst_valid", o_valid, 0);
      checkOutput("rst_instr", o_instr, 0);
      checkOutput("rst_pc", o_pc, 0);
      checkOutput("rst_except", o_except, 0);
      checkOutput("rst_addr", o_addr, 0);
      checkOutput("rst_rd_cmd", o_rd_cmd, 0);
      checkOutput("rst_stall", o_fetch_stall, 1);
      clearLogs();
      nrst = 1'b1;
      rel  = cyc;
      waitCycles(8);
      checkOutput("first_cmd_cyc", qAt(cmdCyc, 0), rel + 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("stream_cmd_addr", qAt(cmdAddr, i), 32'(4 * i));
         checkOutput("stream_cmd_cyc", qAt(cmdCyc, i), rel + 1 + i);
      end
      checkOutput("first_valid_cyc", qAt(popCyc, 0), rel + 3);
      for (int i = 0; i < 3; i++) begin
         checkOutput("stream_pop_pc", qAt(popPc, i), 32'(4 * i));
         checkOutput("stream_pop_instr", qAt(popInstr, i), memWord(32'(4 * i)));
      end
      checkOutput("stream_pop_exc", qAt(popExc, 0), 0);

      // Backpressure: queue fills to DEPTH, then drains in order
      i_ready = 1'b0;
      resetDut(rel);
      waitCycles(12);
      checkOutput("full_cmd_count", cmdAddr.size(), 4);
      checkOutput("full_last_addr", qAt(cmdAddr, 3), 12);
      checkOutput("full_no_pop", popPc.size(), 0);
      checkOutput("full_head_valid", o_valid, 1);
      checkOutput("full_head_pc", o_pc, 0);
      checkOutput("full_head_instr", o_instr, memWord(32'd0));
      checkOutput("full_no_cmd", o_rd_cmd, 0);
      clearLogs();
      i_ready = 1'b1;
      k = cyc;
      waitCycles(10);
      for (int i = 0; i < 5; i++) begin
         checkOutput("drain_pop_pc", qAt(popPc, i), 32'(4 * i));
      end
      checkOutput("resume_addr", qAt(cmdAddr, 0), 16);
      checkOutput("resume_cyc", qAt(cmdCyc, 0), k + 1);

      // Redirect while the IFU is busy discards the stale response
      ifuLat = 3;
      resetDut(rel);
      waitCycles(3);
      pulseRedirect(32'h100, rcyc);
      waitCycles(20);
      checkOutput("busy_cmd0", qAt(cmdAddr, 0), 0);
      checkOutput("busy_cmd1", qAt(cmdAddr, 1), 32'h100);
      checkOutput("busy_cmd1_cyc", qAt(cmdCyc, 1), rcyc + 3);
      checkOutput("busy_first_pc", qAt(popPc, 0), 32'h100);
      checkOutput("busy_first_instr", qAt(popInstr, 0), memWord(32'h100));

      // Bus error at address 8 halts fetching until a redirect
      ifuLat = 0;
      busErrEn = 1'b1;
      busErrAddr = 32'd8;
      resetDut(rel);
      waitCycles(10);
      checkOutput("err_cmd_count", cmdAddr.size(), 3);
      checkOutput("err_pc", qAt(popPc, 2), 8);
      checkOutput("err_exc", qAt(popExc, 2), 2);
      checkOutput("err_instr", qAt(popInstr, 2), 0);
      checkOutput("err_prev_exc", qAt(popExc, 1), 0);
      clearLogs();
      pulseRedirect(32'h40, rcyc);
      waitCycles(6);
      checkOutput("err_resume_addr", qAt(cmdAddr, 0), 32'h40);
      checkOutput("err_resume_cyc", qAt(cmdCyc, 0), rcyc + 1);
      checkOutput("err_resume_valid_cyc", qAt(popCyc, 0), rcyc + 3);
      checkOutput("err_resume_pc", qAt(popPc, 0), 32'h40);
      busErrEn = 1'b0;

      // Redirect coinciding with a head pop and a response push
      clearLogs();
      applyStimulus(1'b1, 32'h200, 1'b1);
      rcyc = cyc;
      @(negedge clk);
      checkOutput("coll_valid_before", o_valid, 1);
      checkOutput("coll_cmd_blocked", o_rd_cmd, 0);
      @(posedge clk);
      #1;
      i_redir_valid = 1'b0;
      @(negedge clk);
      checkOutput("coll_empty_after", o_valid, 0);
      checkOutput("coll_cmd_after", o_rd_cmd, 1);
      checkOutput("coll_addr_after", o_addr, 32'h200);
      waitCycles(5);
      checkOutput("coll_first_pc", qAt(popPc, 0), 32'h200);
      checkOutput("coll_first_cyc", qAt(popCyc, 0), rcyc + 3);

      // Fetch address wraps past the top of the address space
      clearLogs();
      pulseRedirect(32'hFFFF_FFFC, rcyc);
      waitCycles(6);
      checkOutput("wrap_cmd0", qAt(cmdAddr, 0), 32'hFFFF_FFFC);
      checkOutput("wrap_cmd1", qAt(cmdAddr, 1), 0);
      checkOutput("wrap_pop0", qAt(popPc, 0), 32'hFFFF_FFFC);
      checkOutput("wrap_pop1", qAt(popPc, 1), 0);

      // Misaligned redirect target is fetched and tagged as an align error
      clearLogs();
      pulseRedirect(32'h302, rcyc);
      waitCycles(6);
      checkOutput("align_cmd_count", cmdAddr.size(), 1);
      checkOutput("align_cmd_addr", qAt(cmdAddr, 0), 32'h302);
      checkOutput("align_pc", qAt(popPc, 0), 32'h302);
      checkOutput("align_exc", qAt(popExc, 0), 1);
      checkOutput("align_instr", qAt(popInstr, 0), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
